hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Parametrised hazard controller for the `riscv_pipeline` core. It replaces the forwarding-only hazard unit with a shadow scoreboard of in-flight writers, and generates three things: registered bypass selects for the execute stage, load-use stalls for multi-cycle load latency, and flush on execute-stage redirect. Bypass depth and load latency are generic. Saturating stall and flush counters are included for performance dumps.

## Interface
Reset is synchronous and active-high. One clock, `clk`; reset port is `reset`.

Parameters:
- `RA_W`, 5, register address width.
- `NBYP`, 2, number of bypass stages after execute (1 = mem, 2 = wb, …).
- `LOAD_LAT`, 1, extra cycles after the mem stage before load data can be forwarded. Must satisfy `LOAD_LAT < NBYP`.
- `CNT_W`, 32, performance counter width.

Ports:
- `clk`, in, 1, clock.
- `reset`, in, 1, synchronous active-high reset.
- `de_valid`, in, 1, decode holds a valid instruction.
- `de_rs1`, `de_rs2`, in, RA_W, source registers of the decode instruction.
- `de_use1`, `de_use2`, in, 1, the corresponding source is actually read.
- `de_rd`, in, RA_W, destination register.
- `de_we`, in, 1, instruction writes `de_rd`.
- `de_load`, in, 1, instruction is a load.
- `ex_redirect`, in, 1, branch or jump taken in execute (the `pc_r` path).
- `stall`, out, 1, hold fetch and decode, and insert a bubble into execute.
- `flush`, out, 1, kill fetch and decode contents.
- `src1`, `src2`, out, `$clog2(NBYP+1)`, execute operand select. 0 = register file; k = bypass stage k.
- `stall_cnt`, `flush_cnt`, out, CNT_W, saturating event counters.

## Operation
- **Shadow pipeline.** Entries `e[0..NBYP-1]` hold {valid, we, rd, load}. `e[0]` mirrors execute and `e[k]` mirrors bypass stage k.
- **Advance.** Every cycle, `e[k] <= e[k-1]`.
- **Execute-entry rule.** `e[0]` receives the decode instruction only if `de_valid && !stall && !flush`. Otherwise `e[0]` receives a bubble (valid = 0).
- **Producer match.** For each used source `rs` with `rs != 0`, find the smallest j with `e[j].valid && e[j].we && e[j].rd == rs`.
- **Forwarding select.** The matched producer will sit in stage j+1 when the consumer reaches execute.
  - `srcN` register <= j+1.
  - If there is no match, or the source is unused, or `rs == 0`: `srcN` <= 0.
- **Load-use stall.** If the matched producer is a load and `j < LOAD_LAT`, then `stall = 1` (combinational). The stall is re-evaluated every cycle and holds until the load has advanced far enough.
- **Select update on bubbles.** `srcN` update is suppressed (forced to 0) when a bubble enters `e[0]`.
- **Register file ordering.** Producers beyond stage NBYP are read from the register file. Decode's register file is write-first: a same-cycle write-back is visible to the read.
- **Flush.** `flush = ex_redirect` (combinational).
- **Stall/redirect priority.** `stall` is forced to 0 when `ex_redirect` is asserted, because redirect has priority.
- **Counters.**
  - `stall_cnt` +1 per cycle with `stall = 1`.
  - `flush_cnt` +1 per cycle with `flush = 1`.
  - Both saturate at all-ones.

## Timing
- **Reset.** During reset and on the cycle following it:
  - all `e[k].valid` = 0;
  - `src1` = `src2` = 0;
  - both counters = 0;
  - `stall` = `flush` = 0. These are gated by `reset` for the whole reset cycle.
- **Latency.** `stall` and `flush` respond in the same cycle (combinational from decode and execute inputs). `src1`/`src2` have 1-cycle latency: they are registered at decode→execute and valid for the instruction currently in execute.
- **Stall length.** Load-use stall length is `LOAD_LAT - j` cycles for a producer found at `e[j]`. With defaults and a back-to-back load, the stall is 1 cycle.
- **Redirect during stall.** Redirect cancels the stall in that cycle, and the decode instruction is discarded; no bubble double-count.
- **Reset during a stall.** Reset mid-stall clears the scoreboard. Following instructions issue without stall, because register file values are architecturally assumed.

## Structure
- **Package `riscv_structures`:**
  - add `hz_entry_s` {valid, we, rd, load};
  - generalise `hu_src_e` to a parametrised select; the constant 0 means REGFILE.
- **Sub-module `hz_match`:** combinational priority match of one source against `e[]`. Outputs {hit, index, is_load}. Instantiated twice.
- **`riscv_pipeline` integration:** `riscv_pipeline` wires `stall` into fetch and decode hold enables, and `flush` into their kill.

## Test plan
- **ALU back-to-back:** `add x5` then `sub` with rs1 = x5 → `stall` = 0; next cycle `src1` = 1.
- **Load-use (LOAD_LAT = 1):** `lw x6` then `add` with rs2 = x6 → `stall` = 1 for exactly 1 cycle; on issue, `src2` = 2; `stall_cnt` = 1.
- **Register x0:** producer rd = 0, we = 1; consumer rs1 = 0 → `src1` = 0, no stall.
- **Nearest producer wins:** x7 written at distance 1 and at distance 2 → `src1` = 1. Unused rs2 = x7 → `src2` = 0.
- **Redirect during load-use stall:** `ex_redirect` = 1 on the stall cycle → `stall` = 0, `flush` = 1, `flush_cnt` +1, `stall_cnt` unchanged, `e[0]` is a bubble.
- **Reset mid-stall:** reset during a stall → next cycle counters = 0, `src1`/`src2` = 0, and the same consumer issues with no stall.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// riscv_structures: shared hazard-controller types (scoreboard entry, select encoding).
package riscv_structures;
  localparam int RA_W_MAX = 16;
  localparam int SRC_REGFILE = 0;
  typedef struct packed {
    logic                valid;
    logic                we;
    logic [RA_W_MAX-1:0] rd;
    logic                load;
  } hz_entry_s;
endpackage

// File: rtl/hazard_ctrl_match.sv
// hz_match: priority match of one source register against the shadow pipeline, nearest entry wins.
module hz_match
  import riscv_structures::*;
#(
  parameter int NBYP = 2,
  parameter int IW   = $clog2(NBYP + 1)
) (
  input  hz_entry_s [NBYP-1:0]     i_e,
  input  logic      [RA_W_MAX-1:0] i_rs,
  input  logic                     i_use,
  output logic                     o_hit,
  output logic      [IW-1:0]       o_idx,
  output logic                     o_load
);
  always_comb begin
    o_hit  = 1'b0;
    o_idx  = '0;
    o_load = 1'b0;
    for (int k = NBYP - 1; k >= 0; k--)
      if (i_use && i_rs != '0 && i_e[k].valid && i_e[k].we && i_e[k].rd == i_rs) begin
        o_hit  = 1'b1;
        o_idx  = IW'(k);
        o_load = i_e[k].load;
      end
  end
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: scoreboard-based bypass select, load-use stall and redirect flush with saturating perf counters.
module hazard_ctrl
  import riscv_structures::*;
#(
  parameter int RA_W     = 5,
  parameter int NBYP     = 2,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         de_valid,
  input  logic [RA_W-1:0]              de_rs1,
  input  logic [RA_W-1:0]              de_rs2,
  input  logic                         de_use1,
  input  logic                         de_use2,
  input  logic [RA_W-1:0]              de_rd,
  input  logic                         de_we,
  input  logic                         de_load,
  input  logic                         ex_redirect,
  output logic                         stall,
  output logic                         flush,
  output logic [$clog2(NBYP+1)-1:0]    src1,
  output logic [$clog2(NBYP+1)-1:0]    src2,
  output logic [CNT_W-1:0]             stall_cnt,
  output logic [CNT_W-1:0]             flush_cnt
);
  localparam int SW = $clog2(NBYP + 1);
  hz_entry_s [NBYP-1:0] r_e;
  hz_entry_s            w_new;
  logic                 w_hit1, w_hit2, w_ld1, w_ld2, w_issue;
  logic [SW-1:0]        w_idx1, w_idx2;
  hz_match #(.NBYP(NBYP)) u_m1 (
    .i_e(r_e), .i_rs(RA_W_MAX'(de_rs1)), .i_use(de_use1),
    .o_hit(w_hit1), .o_idx(w_idx1), .o_load(w_ld1)
  );
  hz_match #(.NBYP(NBYP)) u_m2 (
    .i_e(r_e), .i_rs(RA_W_MAX'(de_rs2)), .i_use(de_use2),
    .o_hit(w_hit2), .o_idx(w_idx2), .o_load(w_ld2)
  );
  // a load at e[j] is not forwardable until it has advanced LOAD_LAT stages
  assign stall = !reset && !ex_redirect &&
                 ((w_hit1 && w_ld1 && int'(w_idx1) < LOAD_LAT) ||
                  (w_hit2 && w_ld2 && int'(w_idx2) < LOAD_LAT));
  assign flush   = !reset && ex_redirect;
  assign w_issue = de_valid && !stall && !flush;
  assign w_new   = w_issue ? hz_entry_s'{valid: 1'b1, we: de_we, rd: RA_W_MAX'(de_rd), load: de_load}
                           : hz_entry_s'('0);
  always_ff @(posedge clk) begin
    if (reset) begin
      r_e       <= '0;
      src1      <= SW'(SRC_REGFILE);
      src2      <= SW'(SRC_REGFILE);
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      for (int k = NBYP - 1; k > 0; k--) r_e[k] <= r_e[k-1];
      r_e[0]    <= w_new;
      src1      <= (w_issue && w_hit1) ? w_idx1 + SW'(1) : SW'(SRC_REGFILE);
      src2      <= (w_issue && w_hit2) ? w_idx2 + SW'(1) : SW'(SRC_REGFILE);
      stall_cnt <= stall_cnt + CNT_W'(stall && !(&stall_cnt));
      flush_cnt <= flush_cnt + CNT_W'(flush && !(&flush_cnt));
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed plus random checks of hazard_ctrl against a cycle-history reference model.
module tb_hazard_ctrl;
  localparam int NB = 2;
  localparam int LL = 1;
  localparam int CW = 6;
  localparam int CMAX = (1 << CW) - 1;
  logic clk = 1'b0, reset = 1'b1;
  logic de_valid = 0, de_use1 = 0, de_use2 = 0, de_we = 0, de_load = 0, ex_redirect = 0;
  logic [4:0] de_rs1 = 0, de_rs2 = 0, de_rd = 0;
  logic stall, flush;
  logic [1:0] src1, src2;
  logic [CW-1:0] stall_cnt, flush_cnt;
  int n_cmp = 0, n_bad = 0;
  typedef struct { bit v; bit we; bit ld; int rd; } ent_t;
  ent_t lg [0:8191];
  int t = 0, first = 0;
  int ms1 = 0, ms2 = 0, mcs = 0, mcf = 0;
  hazard_ctrl #(.RA_W(5), .NBYP(NB), .LOAD_LAT(LL), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .de_valid(de_valid), .de_rs1(de_rs1), .de_rs2(de_rs2),
    .de_use1(de_use1), .de_use2(de_use2), .de_rd(de_rd), .de_we(de_we), .de_load(de_load),
    .ex_redirect(ex_redirect), .stall(stall), .flush(flush), .src1(src1), .src2(src2),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );
  always #5 clk = ~clk;
  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (time %0t)", nm, act, exp, $time);
    end
  endtask
  // producer = most recent instruction that entered execute within the last NB cycles since reset
  function automatic void find(input int rs, input bit u, output bit f, output int j, output bit ld);
    f = 0; j = 0; ld = 0;
    if (u && rs != 0)
      for (int d = 1; d <= NB && !f; d++) begin
        int c = t - d;
        if (c >= first && lg[c].v && lg[c].we && lg[c].rd == rs) begin
          f = 1; j = d - 1; ld = lg[c].ld;
        end
      end
  endfunction
  initial begin
    bit f1, f2, l1, l2, es, ef, iss;
    int j1, j2;
    forever begin
      @(negedge clk);
      es = 0; ef = 0; f1 = 0; f2 = 0; l1 = 0; l2 = 0; j1 = 0; j2 = 0;
      if (!reset) begin
        find(int'(de_rs1), de_use1, f1, j1, l1);
        find(int'(de_rs2), de_use2, f2, j2, l2);
        ef = ex_redirect;
        es = !ex_redirect && ((f1 && l1 && j1 < LL) || (f2 && l2 && j2 < LL));
      end
      cmp("stall", 32'(stall), 32'(es));
      cmp("flush", 32'(flush), 32'(ef));
      cmp("src1", 32'(src1), ms1);
      cmp("src2", 32'(src2), ms2);
      cmp("stall_cnt", 32'(stall_cnt), mcs);
      cmp("flush_cnt", 32'(flush_cnt), mcf);
      if (reset) begin
        ms1 = 0; ms2 = 0; mcs = 0; mcf = 0;
        lg[t] = '{v: 0, we: 0, ld: 0, rd: 0};
        first = t + 1;
      end else begin
        iss = de_valid && !es && !ef;
        lg[t] = '{v: iss, we: de_we, ld: de_load, rd: int'(de_rd)};
        ms1 = (iss && f1) ? j1 + 1 : 0;
        ms2 = (iss && f2) ? j2 + 1 : 0;
        if (es && mcs < CMAX) mcs++;
        if (ef && mcf < CMAX) mcf++;
      end
      t++;
    end
  end
  task automatic drv(input bit v, input int r1, input bit u1, input int r2, input bit u2,
                     input int rd, input bit we, input bit ld, input bit rr);
    @(posedge clk); #1;
    de_valid = v; de_rs1 = 5'(r1); de_use1 = u1; de_rs2 = 5'(r2); de_use2 = u2;
    de_rd = 5'(rd); de_we = we; de_load = ld; ex_redirect = rr;
  endtask
  task automatic nop(); drv(0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic at(); @(negedge clk); #1; endtask
  task automatic do_reset();
    @(posedge clk); #1; reset = 1;
    de_valid = 0; de_use1 = 0; de_use2 = 0; de_we = 0; de_load = 0; ex_redirect = 0;
    @(posedge clk); #1; reset = 0;
  endtask
  initial begin
    @(posedge clk); #1; reset = 1;
    at(); cmp("rst_src1", 32'(src1), 0); cmp("rst_stall_cnt", 32'(stall_cnt), 0);
    do_reset();
    drv(1, 0, 0, 0, 0, 5, 1, 0, 0);
    drv(1, 5, 1, 0, 0, 8, 1, 0, 0);
    at(); cmp("alu_b2b_stall", 32'(stall), 0);
    nop(); at(); cmp("alu_b2b_src1", 32'(src1), 1);
    do_reset();
    drv(1, 0, 0, 0, 0, 6, 1, 1, 0);
    drv(1, 0, 0, 6, 1, 9, 1, 0, 0);
    at(); cmp("lu_stall_on", 32'(stall), 1);
    drv(1, 0, 0, 6, 1, 9, 1, 0, 0);
    at(); cmp("lu_stall_off", 32'(stall), 0); cmp("lu_stall_cnt", 32'(stall_cnt), 1);
    nop(); at(); cmp("lu_src2", 32'(src2), 2);
    do_reset();
    drv(1, 0, 0, 0, 0, 0, 1, 1, 0);
    drv(1, 0, 1, 0, 0, 3, 1, 0, 0);
    at(); cmp("x0_stall", 32'(stall), 0);
    nop(); at(); cmp("x0_src1", 32'(src1), 0);
    drv(1, 0, 0, 0, 0, 7, 1, 0, 0);
    drv(1, 0, 0, 0, 0, 7, 1, 0, 0);
    drv(1, 7, 1, 7, 0, 2, 1, 0, 0);
    nop(); at(); cmp("near_src1", 32'(src1), 1); cmp("unused_src2", 32'(src2), 0);
    do_reset();
    drv(1, 0, 0, 0, 0, 6, 1, 1, 0);
    drv(1, 0, 0, 6, 1, 9, 1, 0, 1);
    at(); cmp("rd_stall", 32'(stall), 0); cmp("rd_flush", 32'(flush), 1);
    drv(1, 0, 0, 6, 1, 9, 1, 0, 0);
    at(); cmp("rd_flush_cnt", 32'(flush_cnt), 1); cmp("rd_stall_cnt", 32'(stall_cnt), 0);
    cmp("rd_bubble_src2", 32'(src2), 0); cmp("rd_after_stall", 32'(stall), 0);
    nop(); at(); cmp("rd_after_src2", 32'(src2), 2);
    do_reset();
    drv(1, 0, 0, 0, 0, 6, 1, 1, 0);
    drv(1, 0, 0, 6, 1, 9, 1, 0, 0);
    at(); cmp("rs_stall_pre", 32'(stall), 1);
    @(posedge clk); #1; reset = 1;
    at(); cmp("rs_stall_in_reset", 32'(stall), 0);
    @(posedge clk); #1; reset = 0;
    at(); cmp("rs_stall_post", 32'(stall), 0); cmp("rs_stall_cnt", 32'(stall_cnt), 0);
    cmp("rs_src1", 32'(src1), 0); cmp("rs_src2", 32'(src2), 0);
    nop(); at(); cmp("rs_issue_src2", 32'(src2), 0);
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      reset = ($urandom_range(0, 99) == 0);
      de_valid = ($urandom_range(0, 3) != 0);
      de_rs1 = 5'($urandom_range(0, 7)); de_rs2 = 5'($urandom_range(0, 7));
      de_use1 = 1'($urandom_range(0, 1)); de_use2 = 1'($urandom_range(0, 1));
      de_rd = 5'($urandom_range(0, 7)); de_we = ($urandom_range(0, 3) != 0);
      de_load = ($urandom_range(0, 2) == 0); ex_redirect = ($urandom_range(0, 9) == 0);
    end
    do_reset();
    for (int i = 0; i < 70; i++) begin
      drv(1, 0, 0, 0, 0, 6, 1, 1, 0);
      drv(1, 0, 0, 6, 1, 1, 1, 0, 0);
      drv(1, 0, 0, 6, 1, 1, 1, 0, 0);
    end
    nop(); at(); cmp("sat_stall_cnt", 32'(stall_cnt), CMAX);
    for (int i = 0; i < 70; i++) drv(1, 0, 0, 0, 0, 1, 1, 0, 1);
    nop(); at(); cmp("sat_flush_cnt", 32'(flush_cnt), CMAX);
    @(negedge clk); #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
